// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit adder computing a + b + cin. It reuses one 4-bit
// carry-lookahead slice over WIDTH/4 cycles, least-significant nibble first.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst        - asynchronous, active-high reset
//   in_valid   - producer offers an operand set
//   in_ready   - block can accept operands (registered, high only in IDLE)
//   a, b, cin  - operands and carry-in; sampled only at the accept edge
//   out_valid  - result is held and valid (registered, high only in DONE)
//   out_ready  - consumer takes the result
//   sum        - a + b + cin modulo 2^WIDTH
//   cout       - carry out of the MSB
//   ovf        - two's-complement overflow
//   busy       - high while an operation is in RUN or DONE

// 4-bit carry-lookahead slice: all carries come directly from generate/propagate terms.
module cla4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Two-level lookahead; no carry ripples through a previous carry.
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign S    = p ^ c[3:0];
    assign Cout = c[4];

endmodule

module cla_seq_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    // idx must be at least one bit wide; for WIDTH=4 it never needs to wrap.
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    // Reject widths that are not a positive multiple of four.
    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
            $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_d;
    logic               cout_q;
    logic               ovf_q;
    logic               ovf_d;
    logic               out_valid_q;
    logic               busy_q;
    logic               in_ready_q;

    logic [3:0]         slice_a;
    logic [3:0]         slice_b;
    logic [3:0]         slice_s;
    logic               slice_cout;
    logic               last_nibble;

    // The single shared slice; fed from the registered operands and carry.
    cla4 u_slice (
        .A    (slice_a),
        .B    (slice_b),
        .Cin  (carry_q),
        .S    (slice_s),
        .Cout (slice_cout)
    );

    // Select the current nibble and merge the slice result into the sum.
    always_comb begin
        slice_a = 4'd0;
        slice_b = 4'd0;
        sum_d   = sum_q;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a          = a_q[4*i +: 4];
                slice_b          = b_q[4*i +: 4];
                sum_d[4*i +: 4]  = slice_s;
            end
        end
        last_nibble = (idx_q == IDX_W'(NIBBLES - 1));
        // Overflow: operands share a sign and the result's sign differs from it.
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    // Accept only once in_ready is visible to the producer.
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_nibble) begin
                        cout_q      <= slice_cout;
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Handoff: back to IDLE, ready again next cycle; result held.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Testbench for cla_seq_adder.
// - A WIDTH=16 instance runs directed vectors and the multi-cycle corner cases.
// - WIDTH=4 and WIDTH=32 instances run random back-to-back streams against a golden model.
`timescale 1ns/1ps
module tb_cla_seq_adder;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- WIDTH=16 directed instance ----------------
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    cla_seq_adder #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    vec_t vecs [10];

    // One full transaction; latency counts edges after the accept edge.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tc, output logic [15:0] rs,
                         output logic rc, output logic ro, output int lat);
        @(negedge clk);
        a        = ta;
        b        = tb_;
        cin      = tc;
        in_valid = 1'b1;
        lat      = -1;
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        chk("op_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        // Scramble operands after accept; the result must not change.
        in_valid = 1'b0;
        a        = ~ta;
        b        = 16'($urandom);
        cin      = ~tc;
        for (int k = 0; k <= 20; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        rs        = sum;
        rc        = cout;
        ro        = ovf;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] rs;
        logic        rc;
        logic        ro;
        int          lat;
        int          seen;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[8] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
        vecs[9] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_sum",       64'(sum),       64'(0));
        chk("rst_cout",      64'(cout),      64'(0));
        chk("rst_ovf",       64'(ovf),       64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, rs, rc, ro, lat);
            chk($sformatf("vec%0d_sum", i),  64'(rs),  64'(vecs[i].esum));
            chk($sformatf("vec%0d_cout", i), 64'(rc),  64'(vecs[i].ecout));
            chk($sformatf("vec%0d_ovf", i),  64'(ro),  64'(vecs[i].eovf));
            chk($sformatf("vec%0d_lat", i),  64'(lat), 64'(4));
        end

        // Backpressure in DONE with in_valid pulsing
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        chk("bp_valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 3; i++) begin
            in_valid  = (i % 2 == 0);
            a         = 16'hFFFF;
            b         = 16'hFFFF;
            out_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("bp%0d_sum", i),       64'(sum),       64'(16'h5556));
            chk($sformatf("bp%0d_cout", i),      64'(cout),      64'(0));
            chk($sformatf("bp%0d_ovf", i),       64'(ovf),       64'(0));
            chk($sformatf("bp%0d_in_ready", i),  64'(in_ready),  64'(0));
            chk($sformatf("bp%0d_out_valid", i), 64'(out_valid), 64'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_rel_out_valid", 64'(out_valid), 64'(0));
        chk("bp_rel_in_ready",  64'(in_ready),  64'(1));
        chk("bp_rel_busy",      64'(busy),      64'(0));
        chk("bp_rel_sum_held",  64'(sum),       64'(16'h5556));

        // Asynchronous reset after two RUN cycles
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy",        64'(busy), 64'(1));
        chk("mid_partial_sum", 64'(sum),  64'(16'h0056));
        #2 rst = 1'b1;
        #1;
        chk("arst_sum",       64'(sum),       64'(0));
        chk("arst_cout",      64'(cout),      64'(0));
        chk("arst_ovf",       64'(ovf),       64'(0));
        chk("arst_busy",      64'(busy),      64'(0));
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_in_ready",  64'(in_ready),  64'(0));
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("arst_no_valid", 64'(seen), 64'(0));
        do_op(16'h00FF, 16'h0001, 1'b0, rs, rc, ro, lat);
        chk("after_rst_sum",  64'(rs),  64'(16'h0100));
        chk("after_rst_cout", 64'(rc),  64'(0));
        chk("after_rst_lat",  64'(lat), 64'(4));

        // Wait for the random streams, bounded
        for (int k = 0; k < 40000 && !(g_rand[0].done_flag && g_rand[1].done_flag); k++)
            @(negedge clk);
        chk("rand_streams_done", 64'(g_rand[0].done_flag && g_rand[1].done_flag), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- WIDTH=4 and WIDTH=32 random streams ----------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_rand
        localparam int unsigned W = (gi == 0) ? 4 : 32;
        localparam int unsigned N = W / 4;

        logic         r_rst;
        logic         r_in_valid;
        logic         r_in_ready;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        logic         r_cin;
        logic         r_out_valid;
        logic         r_out_ready;
        logic [W-1:0] r_sum;
        logic         r_cout;
        logic         r_ovf;
        logic         r_busy;
        bit           done_flag = 1'b0;
        logic [W+1:0] exp_q [$];

        cla_seq_adder #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst       (r_rst),
            .in_valid  (r_in_valid),
            .in_ready  (r_in_ready),
            .a         (r_a),
            .b         (r_b),
            .cin       (r_cin),
            .out_valid (r_out_valid),
            .out_ready (r_out_ready),
            .sum       (r_sum),
            .cout      (r_cout),
            .ovf       (r_ovf),
            .busy      (r_busy)
        );

        initial begin
            int           ops_acc;
            int           ops_done;
            int           cyc;
            int           acc_cyc;
            bit           waiting;
            bit           drop;
            logic [W:0]   full;
            logic         ovf_m;
            logic [W+1:0] e;

            ops_acc     = 0;
            ops_done    = 0;
            cyc         = 0;
            acc_cyc     = 0;
            waiting     = 1'b0;
            drop        = 1'b0;
            r_rst       = 1'b1;
            r_in_valid  = 1'b0;
            r_out_ready = 1'b0;
            r_a         = '0;
            r_b         = '0;
            r_cin       = 1'b0;
            repeat (2) @(negedge clk);
            r_rst = 1'b0;

            while (ops_done < 200 && cyc < 30000) begin
                @(negedge clk);
                cyc++;
                // acc_cyc is the negedge just after the accept edge
                if (waiting && r_out_valid) begin
                    chk($sformatf("rand_w%0d_lat", W), 64'(cyc - acc_cyc), 64'(N));
                    waiting = 1'b0;
                end
                if (drop) begin
                    r_in_valid = 1'b0;
                    drop       = 1'b0;
                end
                if (!r_in_valid && ops_acc < 200 && $urandom_range(0, 1) == 1) begin
                    r_in_valid = 1'b1;
                    r_a        = W'($urandom);
                    r_b        = W'($urandom);
                    r_cin      = 1'($urandom_range(0, 1));
                end
                r_out_ready = ($urandom_range(0, 2) != 0);

                if (r_in_valid && r_in_ready) begin
                    full  = (W+1)'(r_a) + (W+1)'(r_b) + (W+1)'(r_cin);
                    ovf_m = (r_a[W-1] == r_b[W-1]) && (full[W-1] != r_a[W-1]);
                    exp_q.push_back({ovf_m, full});
                    ops_acc++;
                    acc_cyc = cyc + 1;
                    waiting = 1'b1;
                    drop    = 1'b1;
                end
                if (r_out_valid && r_out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("rand_w%0d_unexpected", W), 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("rand_w%0d_sum", W),  64'(r_sum),  64'(e[W-1:0]));
                        chk($sformatf("rand_w%0d_cout", W), 64'(r_cout), 64'(e[W]));
                        chk($sformatf("rand_w%0d_ovf", W),  64'(r_ovf),  64'(e[W+1]));
                    end
                    ops_done++;
                end
            end
            chk($sformatf("rand_w%0d_ops", W), 64'(ops_done), 64'(200));
            r_in_valid  = 1'b0;
            r_out_ready = 1'b0;
            done_flag   = 1'b1;
        end
    end

endmodule
